ps2_move_decoder: RTL and testbench



---
 rtl/snake_pkg.sv | 39 +++
 rtl/ps2_frame_rx.sv | 137 +++++++++++++
 rtl/ps2_move_decoder.sv | 102 ++++++++++
 tb/tb_ps2_move_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared scan-code constants and direction/state encodings for the PS/2 input path
// and the snake direction logic.
package snake_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'b00,
    RX_DATA   = 2'b01,
    RX_PARITY = 2'b10,
    RX_STOP   = 2'b11
  } rx_state_t;

  function automatic logic is_arrow(input logic [7:0] sc);
    return (sc == SC_UP) || (sc == SC_DOWN) || (sc == SC_LEFT) || (sc == SC_RIGHT);
  endfunction

  function automatic dir_t arrow_dir(input logic [7:0] sc);
    case (sc)
      SC_DOWN:  return DOWN;
      SC_LEFT:  return LEFT;
      SC_RIGHT: return RIGHT;
      default:  return UP;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 byte receiver: input synchronizers, clock glitch filter, 11-bit frame FSM
// and an inactivity timeout that abandons partial frames.
module ps2_frame_rx
  import snake_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output rx_state_t  rx_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall;
  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  // Filtered clock flips only once the synchronized level has disagreed with it
  // for FILTER_LEN consecutive samples; the flip cycle to 0 is the sampling edge.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    fall      = 1'b0;
    if (clk_sync_q != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
        fall   = filt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (state_q == RX_IDLE || fall) tmo_d = '0;
    else if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_d = tmo_q + 1'b1;
    else tmo_d = tmo_q;

    if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_sync_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_sync_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_sync_q && (^{shift_q, par_q})) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign rx_state = state_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// Turns received PS/2 bytes into single turn pulses: tracks the break prefix and
// per-arrow held flags so typematic repeats do not retrigger a turn.
module ps2_move_decoder
  import snake_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:1] move,
  output logic [1:0] dir_code,
  output logic       dir_valid,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err,
  output rx_state_t  rx_state
);

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (frame_err),
    .rx_state(rx_state)
  );

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [3:0] held_q, held_d;
  logic [2:1] move_q, move_d;
  dir_t       dir_code_q, dir_code_d;
  logic       dir_valid_q, dir_valid_d;
  dir_t       key;

  // The E0 prefix is tracked but arrows act identically with or without it.
  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    move_d      = 2'b00;
    dir_valid_d = 1'b0;
    dir_code_d  = dir_code_q;
    key         = arrow_dir(rx_byte);
    if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (is_arrow(rx_byte)) begin
          if (brk_q) begin
            held_d[key] = 1'b0;
          end else if (!held_q[key]) begin
            held_d[key] = 1'b1;
            dir_valid_d = 1'b1;
            dir_code_d  = key;
            move_d      = (key == UP || key == LEFT) ? 2'b01 : 2'b10;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= 4'b0000;
      move_q      <= 2'b00;
      dir_code_q  <= DOWN;
      dir_valid_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      move_q      <= move_d;
      dir_code_q  <= dir_code_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  assign move       = move_q;
  assign dir_code   = dir_code_q;
  assign dir_valid  = dir_valid_q;
  assign scan_code  = rx_byte;
  assign scan_valid = rx_valid;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Bench for ps2_move_decoder: drives PS/2 frames, models the arrow-key rules with a
// keyed held table, and compares scan bytes, errors and turn pulses.
module tb_ps2_move_decoder;
  import snake_pkg::*;

  localparam int TMO = 50000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:1] move;
  logic [1:0] dir_code;
  logic       dir_valid;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  rx_state_t  rx_state;

  ps2_move_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .move      (move),
    .dir_code  (dir_code),
    .dir_valid (dir_valid),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err),
    .rx_state  (rx_state)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miss_cnt = 0;

  // Observed events and expected pulses, {move[2:1], dir_code}
  logic [7:0] scan_seen_q[$];
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];
  int         err_seen = 0;
  logic       sv_prev = 1'b0;

  // Reference model state
  logic [3:0] m_held;
  logic       m_brk;
  logic [1:0] m_dir;
  logic [7:0] m_scan;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (scan_valid) scan_seen_q.push_back(scan_code);
      if (frame_err) err_seen++;
      if (dir_valid || move != 2'b00) begin
        got_q.push_back({move, dir_code});
        check("pulse_shape", {30'd0, dir_valid, (move == 2'b01 || move == 2'b10)}, 32'd3);
        check("pulse_latency", {31'd0, sv_prev}, 32'd1);
      end
      sv_prev = scan_valid;
    end else begin
      sv_prev = 1'b0;
    end
  end

  task automatic model_reset();
    m_held = 4'b0000;
    m_brk  = 1'b0;
    m_dir  = 2'b01;
    m_scan = 8'h00;
    exp_q.delete();
    got_q.delete();
    scan_seen_q.delete();
    err_seen = 0;
  endtask

  // Arrow index 0..3 = up, down, left, right; even index turns via move[1]
  task automatic model_byte(input logic [7:0] b);
    int k;
    m_scan = b;
    case (b)
      8'h75:   k = 0;
      8'h72:   k = 1;
      8'h6B:   k = 2;
      8'h74:   k = 3;
      default: k = -1;
    endcase
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b != 8'hE0) begin
      if (k >= 0) begin
        if (m_brk) m_held[k] = 1'b0;
        else if (!m_held[k]) begin
          m_held[k] = 1'b1;
          m_dir = k[1:0];
          exp_q.push_back({((k % 2) == 0) ? 2'b01 : 2'b10, k[1:0]});
        end
      end
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic v, input int half, input logic glitch);
    ps2_data = v;
    if (glitch) begin
      repeat (half / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (half - half / 2 - 2) @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int half, input int glitch_bit);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, half, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half, glitch_bit == i);
    ps2_bit(p, half, 1'b0);
    ps2_bit(1'b1, half, 1'b0);
    ps2_data = 1'b1;
    repeat (half + 10) @(negedge clk);
  endtask

  task automatic expect_frame(input logic good, input logic [7:0] b, input string tag);
    if (good) begin
      model_byte(b);
      check({tag, "_scan_cnt"}, scan_seen_q.size(), 1);
      if (scan_seen_q.size() > 0) check({tag, "_scan"}, scan_seen_q[0], b);
      check({tag, "_err_cnt"}, err_seen, 0);
    end else begin
      check({tag, "_scan_cnt"}, scan_seen_q.size(), 0);
      check({tag, "_err_cnt"}, err_seen, 1);
    end
    check({tag, "_pulse_cnt"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_pulse"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    scan_seen_q.delete();
    err_seen = 0;
    check({tag, "_dir_code"}, dir_code, m_dir);
    check({tag, "_scan_hold"}, scan_code, m_scan);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_move"}, move, 2'b00);
    check({tag, "_dir_code"}, dir_code, 2'b01);
    check({tag, "_dir_valid"}, dir_valid, 1'b0);
    check({tag, "_scan_code"}, scan_code, 8'h00);
    check({tag, "_scan_valid"}, scan_valid, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_rx_state"}, rx_state, RX_IDLE);
  endtask

  task automatic send_good(input logic [7:0] b, input int half, input string tag);
    send_frame(b, 1'b0, half, -1);
    expect_frame(1'b1, b, tag);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] b;
    logic       bad;
    pool = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h1C, 8'hAA};
    model_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Slow keyboard clock, up arrow make
    send_good(8'h75, 1000, "up_slow");

    // Extended right arrow with typematic repeats, then break and re-press
    for (int r = 0; r < 3; r++) begin
      send_good(8'hE0, 20, "rt_ext");
      send_good(8'h74, 20, "rt_make");
    end
    send_good(8'hE0, 20, "rt_ext");
    send_good(8'hF0, 20, "rt_brk");
    send_good(8'h74, 20, "rt_break");
    send_good(8'hE0, 20, "rt_ext");
    send_good(8'h74, 20, "rt_repress");

    // Parity error leaves scan_code and direction untouched
    send_frame(8'h6B, 1'b1, 20, -1);
    expect_frame(1'b0, 8'h6B, "bad_par");

    // Partial frame abandoned by the timeout
    ps2_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 20, 1'b0);
    ps2_data = 1'b1;
    repeat (TMO + 40) @(negedge clk);
    check("tmo_rx_state", rx_state, RX_IDLE);
    expect_frame(1'b0, 8'h00, "timeout");
    send_good(8'h72, 20, "down_after_tmo");

    // Short clock glitch inside a frame must not add a bit
    send_frame(8'h6B, 1'b0, 20, 2);
    expect_frame(1'b1, 8'h6B, "glitch_left");

    // Reset in the middle of a frame
    ps2_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 20, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("mid_rst");
    model_reset();
    ps2_data = 1'b1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_good(8'h75, 20, "up_after_rst");

    // Non-arrow bytes
    send_good(8'h1C, 20, "unused");
    send_good(8'hAA, 20, "bat");

    // Random byte stream with occasional parity errors
    for (int n = 0; n < 12; n++) begin
      b   = pool[$urandom_range(0, 7)];
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, bad, $urandom_range(15, 20), -1);
      expect_frame(!bad, b, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
